renkon_conv_window: RTL and testbench

- Convolution stage directly downstream of the padded line buffer.
- Each valid cycle it takes one MAXFIL×MAXFIL pixel window and multiplies it tap-by-tap against a locally held weight set.
- Products are reduced through a pipelined adder tree, then rounded and saturated to a fixed-point DWIDTH result.
- Weights are loaded one tap at a time over a simple write port; results go to the downstream accumulate/activation logic.

---
 rtl/renkon_conv_window_pkg.sv | 18 +
 rtl/renkon_adder_tree.sv | 24 ++
 rtl/renkon_conv_window.sv | 75 +++++++
 tb/tb_renkon_conv_window.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/renkon_conv_window_pkg.sv
// renkon_conv_window_pkg: shared widths, accumulator sizing and round/saturate helper
package renkon_conv_window_pkg;
  localparam int DWIDTH = 16;
  localparam int LWIDTH = 8;
  localparam int FRACBIT_DEF = 8;
  localparam logic signed [63:0] DMAX = (64'sd1 <<< (DWIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] DMIN = -(64'sd1 <<< (DWIDTH - 1));

  function automatic int acc_w(input int maxfil);
    return 2 * DWIDTH + $clog2(maxfil * maxfil);
  endfunction

  function automatic logic signed [DWIDTH-1:0] round_sat(input logic signed [63:0] v, input int frac);
    logic signed [63:0] r;
    r = (v + (64'sd1 <<< (frac - 1))) >>> frac;
    return r > DMAX ? DMAX[DWIDTH-1:0] : r < DMIN ? DMIN[DWIDTH-1:0] : r[DWIDTH-1:0];
  endfunction
endpackage

// File: rtl/renkon_adder_tree.sv
// renkon_adder_tree: registered N-input signed adder, inputs sign-extended to OW
module renkon_adder_tree #(
  parameter int N  = 5,
  parameter int IW = 32,
  parameter int OW = 37
) (
  input  logic                 clk,
  input  logic                 xrst,
  input  logic signed [IW-1:0] din [N],
  output logic signed [OW-1:0] dout
);
  logic signed [OW-1:0] s;

  // reduce all inputs at full output width so nothing can overflow
  always_comb begin
    s = '0;
    for (int k = 0; k < N; k++) s = s + OW'(din[k]);
  end

  // one register stage on the sum
  always_ff @(posedge clk or posedge xrst)
    if (xrst) dout <= '0;
    else dout <= s;
endmodule

// File: rtl/renkon_conv_window.sv
// renkon_conv_window: masked MAXFILxMAXFIL window dot product, 4-stage pipeline, round and saturate
module renkon_conv_window
  import renkon_conv_window_pkg::*;
#(
  parameter int MAXFIL  = 5,
  parameter int FRACBIT = FRACBIT_DEF
) (
  input  logic                                   clk,
  input  logic                                   xrst,
  input  logic [LWIDTH-1:0]                      fil_size,
  input  logic                                   win_valid,
  input  logic signed [DWIDTH-1:0]               win_pixel [MAXFIL*MAXFIL],
  input  logic                                   wt_we,
  input  logic [$clog2(MAXFIL*MAXFIL)-1:0]       wt_addr,
  input  logic signed [DWIDTH-1:0]               wt_data,
  output logic                                   out_valid,
  output logic signed [DWIDTH-1:0]               out_data
);
  localparam int N2   = MAXFIL * MAXFIL;
  localparam int PW   = 2 * DWIDTH;
  localparam int ACCW = acc_w(MAXFIL);

  logic signed [DWIDTH-1:0] wt   [N2];
  logic signed [PW-1:0]     prod [N2];
  logic signed [ACCW-1:0]   rsum [MAXFIL];
  logic signed [ACCW-1:0]   tot;
  logic [N2-1:0]            act;
  logic [2:0]               vld;

  // tap is live when inside the top fil_size rows and the newest fil_size columns
  always_comb begin
    act = '0;
    for (int i = 0; i < MAXFIL; i++)
      for (int j = 0; j < MAXFIL; j++)
        act[MAXFIL*i+j] = (i < int'(fil_size)) && (j + int'(fil_size) >= MAXFIL);
  end

  // weight file; out-of-range addresses are dropped
  always_ff @(posedge clk or posedge xrst)
    if (xrst) for (int k = 0; k < N2; k++) wt[k] <= '0;
    else if (wt_we && int'(wt_addr) < N2) wt[wt_addr] <= wt_data;

  // S1: masked full-width products
  always_ff @(posedge clk or posedge xrst)
    if (xrst) for (int k = 0; k < N2; k++) prod[k] <= '0;
    else for (int k = 0; k < N2; k++) prod[k] <= act[k] ? PW'(win_pixel[k]) * PW'(wt[k]) : '0;

  // S2: one adder per row
  for (genvar r = 0; r < MAXFIL; r++) begin : g_row
    logic signed [PW-1:0] rp [MAXFIL];
    for (genvar c = 0; c < MAXFIL; c++) begin : g_col
      assign rp[c] = prod[MAXFIL*r+c];
    end
    renkon_adder_tree #(.N(MAXFIL), .IW(PW), .OW(ACCW)) u_row (
      .clk(clk), .xrst(xrst), .din(rp), .dout(rsum[r])
    );
  end

  // S3: total of row sums
  renkon_adder_tree #(.N(MAXFIL), .IW(ACCW), .OW(ACCW)) u_tot (
    .clk(clk), .xrst(xrst), .din(rsum), .dout(tot)
  );

  // S4 and valid tracking; out_data only moves when a real result arrives
  always_ff @(posedge clk or posedge xrst)
    if (xrst) begin
      vld       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      vld       <= {vld[1:0], win_valid};
      out_valid <= vld[2];
      if (vld[2]) out_data <= round_sat(64'(tot), FRACBIT);
    end
endmodule

// File: tb/tb_renkon_conv_window.sv
// tb_renkon_conv_window: table vectors, directed corner sequences and random windows vs a dot-product model
module tb_renkon_conv_window;
  import renkon_conv_window_pkg::*;
  localparam int MF = 5;
  localparam int N2 = MF * MF;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic xrst = 1'b1;
  logic [LWIDTH-1:0] fil_size = 8'd5;
  logic win_valid = 1'b0;
  logic signed [DWIDTH-1:0] win_pixel [N2];
  logic wt_we = 1'b0;
  logic [4:0] wt_addr = '0;
  logic signed [DWIDTH-1:0] wt_data = '0;
  logic out_valid;
  logic signed [DWIDTH-1:0] out_data;

  renkon_conv_window #(.MAXFIL(MF), .FRACBIT(FB)) dut (
    .clk(clk), .xrst(xrst), .fil_size(fil_size), .win_valid(win_valid),
    .win_pixel(win_pixel), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    logic signed [15:0] val;
    bit chkd;
  } exp_t;
  typedef struct {
    int fil;
    int mode;
    int pix;
    int wt;
    int exp;
  } tv_t;

  exp_t q[$];
  tv_t tv [7];
  logic signed [15:0] mw [N2];
  logic signed [15:0] held;
  bit held_ok;
  bit chk_en = 1'b0;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic signed [15:0] mdl(input int fil);
    longint s = 0;
    for (int i = 0; i < MF; i++)
      for (int j = 0; j < MF; j++)
        if (i < fil && j >= MF - fil) s += longint'(win_pixel[MF*i+j]) * longint'(mw[MF*i+j]);
    s = (s + (64'sd1 <<< (FB - 1))) >>> FB;
    return s > 32767 ? 16'sh7fff : s < -32768 ? 16'sh8000 : 16'(s);
  endfunction

  always @(negedge clk)
    if (chk_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("out_valid", longint'(out_valid), 1);
        if (q[0].chkd) begin
          check("out_data", longint'(out_data), longint'(q[0].val));
          held = q[0].val;
          held_ok = 1'b1;
        end else held_ok = 1'b0;
        void'(q.pop_front());
      end else begin
        check("idle_valid", longint'(out_valid), 0);
        if (held_ok) check("hold_data", longint'(out_data), longint'(held));
      end
    end

  task automatic step(input bit v, input bit we, input int addr, input int data, input bit chkd);
    win_valid = v;
    wt_we = we;
    wt_addr = 5'(addr);
    wt_data = 16'(data);
    if (v) q.push_back('{cyc + 4, mdl(int'(fil_size)), chkd});
    if (we && addr < N2) mw[addr] = 16'(data);
    @(posedge clk);
    #1;
    win_valid = 1'b0;
    wt_we = 1'b0;
  endtask

  task automatic drain();
    repeat (6) step(0, 0, 0, 0, 1);
    check("drained", longint'(q.size()), 0);
  endtask

  task automatic load_all(input int w);
    for (int k = 0; k < N2; k++) step(0, 1, k, w, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N2; k++) begin
      win_pixel[k] = '0;
      mw[k] = '0;
    end
    tv[0] = '{5, 0, 256, 256, 6400};
    tv[1] = '{3, 0, 256, 256, 2304};
    tv[2] = '{3, 1, 256, 256, 0};
    tv[3] = '{1, 2, 1, 128, 1};
    tv[4] = '{1, 2, -1, 128, 0};
    tv[5] = '{5, 0, 32767, 32767, 32767};
    tv[6] = '{5, 0, -32768, 32767, -32768};
    @(posedge clk);
    #1;
    check("reset_valid", longint'(out_valid), 0);
    check("reset_data", longint'(out_data), 0);
    xrst = 1'b0;
    held = '0;
    held_ok = 1'b1;
    chk_en = 1'b1;

    for (int n = 0; n < 7; n++) begin
      fil_size = 8'(tv[n].fil);
      for (int k = 0; k < N2; k++)
        step(0, 1, k, tv[n].mode == 2 ? (k == 4 ? tv[n].wt : 0) : tv[n].wt, 1);
      for (int k = 0; k < N2; k++) begin
        if (tv[n].mode == 0) win_pixel[k] = 16'(tv[n].pix);
        else if (tv[n].mode == 1) win_pixel[k] = (k / MF >= 3 || k % MF < 2) ? 16'(tv[n].pix) : '0;
        else win_pixel[k] = k == 4 ? 16'(tv[n].pix) : 16'($urandom);
      end
      step(1, 0, 0, 0, 1);
      drain();
      check($sformatf("table%0d", n), longint'(out_data), longint'(tv[n].exp));
    end

    fil_size = 8'd5;
    load_all(256);
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < N2; k++) win_pixel[k] = 16'(n * 37 + k * 11 - 150);
      step(1, n == 5, 12, 1024, 1);
    end
    drain();

    for (int b = 0; b < 8; b++) begin
      fil_size = 8'($urandom_range(1, 5));
      for (int n = 0; n < 30; n++) begin
        for (int k = 0; k < N2; k++)
          win_pixel[k] = b % 2 == 0 ? 16'($urandom) : 16'($urandom_range(0, 600) - 300);
        step($urandom % 4 != 0, $urandom % 3 == 0, int'($urandom % 32),
             b % 2 == 0 ? int'($urandom % 65536) : int'($urandom_range(0, 1000)) - 500, 1);
      end
      drain();
    end

    fil_size = 8'd0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    drain();
    fil_size = 8'd7;
    step(1, 0, 0, 0, 0);
    drain();

    fil_size = 8'd5;
    load_all(256);
    for (int k = 0; k < N2; k++) win_pixel[k] = 16'sd256;
    repeat (6) step(1, 0, 0, 0, 1);
    chk_en = 1'b0;
    #2;
    xrst = 1'b1;
    #1;
    check("async_rst_valid", longint'(out_valid), 0);
    check("async_rst_data", longint'(out_data), 0);
    @(posedge clk);
    #1;
    xrst = 1'b0;
    q.delete();
    for (int k = 0; k < N2; k++) mw[k] = '0;
    held = '0;
    held_ok = 1'b1;
    chk_en = 1'b1;
    step(1, 0, 0, 0, 1);
    drain();
    check("post_rst_zero_wt", longint'(out_data), 0);
    load_all(256);
    step(1, 0, 0, 0, 1);
    drain();
    check("post_rst_reload", longint'(out_data), 6400);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
